// File: rtl/pci_target.sv
// rtl/pci_target.sv - PCI 32-bit memory target with fast DEVSEL# and linear bursts
// Optional address/write-data parity checker: define PCI_TGT_PARITY_CHK_EN.
module pci_target #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          ADDR_W    = 6
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire [31:0] ad,
    input  logic [3:0] c_be,
    inout  wire        par,
    input  logic       frame_n,
    input  logic       irdy_n,
    output logic       trdy_n,
    output logic       devsel_n,
    output logic       stop_n,
    output logic       par_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BUSY  = 3'd1;
    localparam logic [2:0] S_WR    = 3'd2;
    localparam logic [2:0] S_RD_TA = 3'd3;
    localparam logic [2:0] S_RD    = 3'd4;
    localparam logic [2:0] S_DISC  = 3'd5;
    localparam logic [2:0] S_TURN  = 3'd6;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              armed_q, armed_d;
    logic              par_q, par_d;
    logic              par_oe_q, par_oe_d;

    logic [31:0] mem [2**ADDR_W];

    logic        hit;
    logic        addr_phase;
    logic        xfer;
    logic        ad_oe;
    logic [31:0] ad_out;

    assign hit = (ad[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) &&
                 (c_be == 4'b0110 || c_be == 4'b0111);
    // armed_q stays low after reset until the bus is seen idle, so a
    // transaction interrupted by reset is not mistaken for an address phase
    assign addr_phase = (state_q == S_IDLE) && !frame_n && armed_q;
    assign xfer       = (state_q == S_WR || state_q == S_RD) && !irdy_n;
    assign ad_oe      = (state_q == S_RD);
    assign ad_out     = mem[ptr_q];

    assign ad  = ad_oe ? ad_out : 32'hzzzz_zzzz;
    assign par = par_oe_q ? par_q : 1'bz;

    assign devsel_n = !(state_q == S_WR || state_q == S_RD_TA ||
                        state_q == S_RD || state_q == S_DISC);
    assign trdy_n   = !(state_q == S_WR || state_q == S_RD);
    assign stop_n   = !(state_q == S_DISC);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        armed_d  = armed_q | (frame_n & irdy_n);
        par_oe_d = ad_oe;
        par_d    = ad_oe ? ^{ad_out, c_be} : par_q;
        case (state_q)
            S_IDLE: begin
                if (!frame_n) begin
                    if (addr_phase && hit) begin
                        ptr_d   = ad[ADDR_W+1:2];
                        state_d = c_be[0] ? S_WR : S_RD_TA;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY:  if (frame_n && irdy_n) state_d = S_IDLE;
            S_WR, S_RD: begin
                if (xfer) begin
                    if (frame_n)               state_d = S_TURN;
                    else if (ptr_q == PTR_MAX) state_d = S_DISC;
                    else                       ptr_d   = ptr_q + ADDR_W'(1);
                end
            end
            S_RD_TA: state_d = S_RD;
            S_DISC:  if (frame_n) state_d = S_TURN;
            S_TURN:  state_d = frame_n ? S_IDLE : S_BUSY;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            armed_q  <= 1'b0;
            par_q    <= 1'b0;
            par_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            armed_q  <= armed_d;
            par_q    <= par_d;
            par_oe_q <= par_oe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_WR && xfer) begin
            for (int b = 0; b < 4; b++) begin
                if (!c_be[b]) mem[ptr_q][8*b +: 8] <= ad[8*b +: 8];
            end
        end
    end

`ifdef PCI_TGT_PARITY_CHK_EN
    logic chk_en_q, chk_en_d;
    logic chk_par_q, chk_par_d;
    logic par_err_q, par_err_d;

    // initiator drives par one cycle after the ad/c_be it covers
    always_comb begin
        chk_en_d  = addr_phase || (state_q == S_WR && xfer);
        chk_par_d = ^{ad, c_be};
        par_err_d = par_err_q | (chk_en_q & (par != chk_par_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_en_q  <= 1'b0;
            chk_par_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            chk_en_q  <= chk_en_d;
            chk_par_q <= chk_par_d;
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_pci_target.sv
// tb/tb_pci_target.sv - directed bench for pci_target with byte-lane memory model
// Parity-checker scenario is included when PCI_TGT_PARITY_CHK_EN is defined.
module tb_pci_target;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        frame_r = 1'b1, irdy_r = 1'b1;
    logic [3:0]  cbe_r = 4'h0;
    logic        tb_ad_en = 1'b0, tb_par_en = 1'b0, flip = 1'b0;
    logic [31:0] tb_ad = 32'h0;
    logic        tb_par = 1'b0;

    logic        exp_devsel = 1'b1, exp_trdy = 1'b1, exp_stop = 1'b1;
    logic        exp_ad_drv = 1'b0, exp_par_drv = 1'b0, exp_par = 1'b0, exp_par_err = 1'b0;
    logic [31:0] exp_ad = 32'h0;

    logic        p_ad_drv, p_tb_en;
    logic [31:0] p_ad, p_tb_ad;
    logic [3:0]  p_cbe;

    logic [31:0] mm [64];
    logic [31:0] wdata [8];

    int total = 0;
    int bad   = 0;
    bit started = 0;

    wire [31:0] ad;
    wire        par;
    logic       trdy_n, devsel_n, stop_n, par_err;

    // bench parks the bus at 0 whenever nobody should drive it
    assign ad  = (tb_ad_en || !exp_ad_drv) ? (tb_ad_en ? tb_ad : 32'h0) : 32'hzzzz_zzzz;
    assign par = (tb_par_en || !exp_par_drv) ? (tb_par_en ? (tb_par ^ flip) : 1'b0) : 1'bz;

    pci_target #(.BASE_ADDR(BASE), .ADDR_W(6)) dut (
        .clk      (clk),
        .rst      (rst_n),
        .ad       (ad),
        .c_be     (cbe_r),
        .par      (par),
        .frame_n  (frame_r),
        .irdy_n   (irdy_r),
        .trdy_n   (trdy_n),
        .devsel_n (devsel_n),
        .stop_n   (stop_n),
        .par_err  (par_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("devsel_n", {31'b0, devsel_n}, {31'b0, exp_devsel});
            check("trdy_n", {31'b0, trdy_n}, {31'b0, exp_trdy});
            check("stop_n", {31'b0, stop_n}, {31'b0, exp_stop});
            check("par_err", {31'b0, par_err}, {31'b0, exp_par_err});
            check("ad", ad, tb_ad_en ? tb_ad : (exp_ad_drv ? exp_ad : 32'h0));
            check("par", {31'b0, par},
                  {31'b0, tb_par_en ? (tb_par ^ flip) : (exp_par_drv ? exp_par : 1'b0)});
        end
    end

    task automatic set_in(input logic fr, input logic ir, input logic [3:0] be,
                          input logic en, input logic [31:0] val);
        frame_r = fr; irdy_r = ir; cbe_r = be; tb_ad_en = en; tb_ad = val;
    endtask

    task automatic exp_set(input logic dv, input logic tr, input logic st,
                           input logic drv, input logic [31:0] val);
        exp_devsel = dv; exp_trdy = tr; exp_stop = st; exp_ad_drv = drv; exp_ad = val;
    endtask

    task automatic exp_idle();
        exp_set(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic exp_xfer(input bit wr, input int p);
        exp_set(1'b0, 1'b0, 1'b1, !wr, mm[p]);
    endtask

    // one clock: par (from either side) follows the ad/c_be of the previous cycle
    task automatic tick();
        @(posedge clk);
        p_ad_drv = exp_ad_drv & rst_n;
        p_ad     = exp_ad;
        p_cbe    = cbe_r;
        p_tb_en  = tb_ad_en;
        p_tb_ad  = tb_ad;
        #2;
        exp_par_drv = p_ad_drv;
        exp_par     = ^{p_ad, p_cbe};
        tb_par_en   = p_tb_en;
        tb_par      = ^{p_tb_ad, p_cbe};
    endtask

    task automatic burst(input logic [3:0] cmd, input logic [31:0] addr, input int n,
                         input int wait_at, input logic [3:0] be);
        bit wr, hit, last;
        int p;
        wr  = (cmd == 4'b0111);
        hit = (addr[31:8] == BASE[31:8]) && (cmd == 4'b0110 || wr);
        p   = int'(addr[7:2]);
        set_in(1'b0, 1'b1, cmd, 1'b1, addr); exp_idle(); tick();
        if (!hit) begin
            for (int i = 0; i < n; i++) begin
                set_in(i == n - 1, 1'b0, be, wr, wdata[i]); exp_idle(); tick();
            end
            set_in(1'b1, 1'b1, 4'h0, 1'b0, 32'h0); exp_idle(); tick();
            return;
        end
        if (!wr) begin
            set_in(n == 1, 1'b0, be, 1'b0, 32'h0); exp_set(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); tick();
        end
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            if (i == wait_at) begin
                set_in(1'b0, 1'b1, be, wr, wdata[i]); exp_xfer(wr, p); tick();
            end
            set_in(last, 1'b0, be, wr, wdata[i]); exp_xfer(wr, p); tick();
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (!be[b]) mm[p][8*b +: 8] = wdata[i][8*b +: 8];
                end
            end
            if (!last && p == 63) begin
                set_in(1'b0, 1'b0, be, 1'b0, 32'h0); exp_set(1'b0, 1'b1, 1'b0, 1'b0, 32'h0); tick();
                set_in(1'b1, 1'b0, be, 1'b0, 32'h0); exp_set(1'b0, 1'b1, 1'b0, 1'b0, 32'h0); tick();
                set_in(1'b1, 1'b1, 4'h0, 1'b0, 32'h0); exp_idle(); tick();
                return;
            end
            p++;
        end
        set_in(1'b1, 1'b1, 4'h0, 1'b0, 32'h0); exp_idle(); tick();
    endtask

    task automatic summary();
        $display("test done: total=%0d bad=%0d", total, bad);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        started = 1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick(); tick();

        wdata[0] = 32'hDEADBEEF;
        burst(4'b0111, BASE + 32'h10, 1, -1, 4'b0000);
        burst(4'b0110, BASE + 32'h10, 1, -1, 4'b0000);
        check("model_deadbeef", mm[4], 32'hDEADBEEF);

        wdata[0] = 32'hFFFFFFFF;
        burst(4'b0111, BASE + 32'h20, 1, -1, 4'b0000);
        wdata[0] = 32'h11223344;
        burst(4'b0111, BASE + 32'h20, 1, -1, 4'b1100);
        burst(4'b0110, BASE + 32'h20, 1, -1, 4'b0000);
        check("model_byte_lanes", mm[8], 32'hFFFF3344);

        for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
        burst(4'b0111, BASE, 4, 2, 4'b0000);
        burst(4'b0110, BASE, 4, 1, 4'b0000);
        for (int i = 0; i < 4; i++) check("model_burst", mm[i], 32'(i + 1));

        for (int i = 0; i < 4; i++) wdata[i] = 32'hBAD0_0000 + 32'(i);
        burst(4'b0110, 32'h2000_0000, 2, -1, 4'b0000);
        burst(4'b0111, 32'h2000_0000, 2, -1, 4'b0000);
        burst(4'b0010, BASE, 1, -1, 4'b0000);

        for (int i = 0; i < 4; i++) wdata[i] = 32'hCAFE_0001 + 32'(i);
        burst(4'b0111, BASE + 32'hF8, 4, -1, 4'b0000);
        check("model_disc62", mm[62], 32'hCAFE0001);
        check("model_disc63", mm[63], 32'hCAFE0002);
        burst(4'b0110, BASE + 32'hF8, 2, -1, 4'b0000);
        burst(4'b0110, BASE + 32'hFC, 2, -1, 4'b0000);

        // reset in the middle of a write burst
        wdata[0] = 32'h0BAD_F00D;
        set_in(1'b0, 1'b1, 4'b0111, 1'b1, BASE + 32'h30); exp_idle(); tick();
        set_in(1'b0, 1'b0, 4'b0000, 1'b1, 32'h1234_5678); exp_set(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
        mm[12] = 32'h1234_5678;
        set_in(1'b0, 1'b0, 4'b0000, 1'b1, 32'h5555_AAAA);
        rst_n = 1'b0; exp_idle(); tick();
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 4'b0000, 1'b1, 32'h6666_BBBB); exp_idle(); tick();
        set_in(1'b0, 1'b1, 4'b0111, 1'b1, BASE + 32'h34); exp_idle(); tick();
        set_in(1'b1, 1'b0, 4'b0000, 1'b1, 32'h7777_CCCC); exp_idle(); tick();
        set_in(1'b1, 1'b1, 4'b0000, 1'b0, 32'h0); exp_idle(); tick();
        burst(4'b0110, BASE + 32'h30, 1, -1, 4'b0000);
        check("model_reset_word", mm[12], 32'h1234_5678);

`ifdef PCI_TGT_PARITY_CHK_EN
        set_in(1'b0, 1'b1, 4'b0111, 1'b1, BASE + 32'h40); exp_idle(); tick();
        set_in(1'b1, 1'b0, 4'b0000, 1'b1, 32'h5A5A_0001); exp_set(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
        mm[16] = 32'h5A5A_0001;
        flip = 1'b1;
        set_in(1'b1, 1'b1, 4'b0000, 1'b0, 32'h0); exp_idle(); tick();
        flip = 1'b0;
        exp_par_err = 1'b1; tick(); tick();
        rst_n = 1'b0; exp_par_err = 1'b0; tick();
        rst_n = 1'b1; tick(); tick();
        burst(4'b0110, BASE + 32'h40, 1, -1, 4'b0000);
`endif

        tick();
        started = 0;
        summary();
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete within 100000 time units");
        bad++;
        summary();
        $finish;
    end

endmodule
